// File: rtl/fifo_wr_packer_pkg.sv
// Shared types for the FIFO write packer: FSM state encoding and default widths.
package fifo_wr_packer_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Result-in / byte-out bundle between the controller, the packer and the FIFO write port.
interface fifo_wr_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                      res_valid;
    logic                      res_wide;
    logic [2*DATA_WIDTH-1:0]   res_data;
    logic                      res_ready;
    logic                      wfull;
    logic                      winc;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      busy;
    logic [CNT_WIDTH-1:0]      bytes_sent;

    // master: controller + FIFO full-flag side; slave: the packer
    modport master (
        output res_valid, res_wide, res_data, wfull,
        input  res_ready, winc, wr_data, busy, bytes_sent
    );

    modport slave (
        input  res_valid, res_wide, res_data, wfull,
        output res_ready, winc, wr_data, busy, bytes_sent
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Serialises 1- or 2-byte results into FIFO writes, low byte first; accept takes 1 cycle, first winc the cycle after.
// Backpressure: wfull stalls the current byte indefinitely (winc drops combinationally); res_ready low until the last byte is written.
module fifo_wr_packer
    import fifo_wr_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_packer_if.slave   bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2*DATA_WIDTH-1:0]  r_hold;
    logic                     r_wide;
    logic [CNT_WIDTH-1:0]     r_bytes_sent;

    logic                     w_capture;
    logic                     w_winc;
    logic                     w_ready;
    logic                     w_busy;
    logic [DATA_WIDTH-1:0]    w_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_wide       <= 1'b0;
            r_bytes_sent <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_hold <= bus.res_data;
                r_wide <= bus.res_wide;
            end
            if (w_winc) begin
                r_bytes_sent <= r_bytes_sent + CNT_WIDTH'(1);
            end
        end
    end

    // winc depends on the live wfull so a write can never land on a full FIFO
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_winc      = 1'b0;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_wr_data   = '0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.res_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                w_busy    = 1'b1;
                w_wr_data = r_hold[DATA_WIDTH-1:0];
                w_winc    = !bus.wfull;
                if (w_winc) begin
                    w_state_nxt = r_wide ? SEND_HI : IDLE;
                end
            end
            SEND_HI: begin
                w_busy    = 1'b1;
                w_wr_data = r_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                w_winc    = !bus.wfull;
                if (w_winc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.res_ready  = w_ready;
    assign bus.busy       = w_busy;
    assign bus.winc       = w_winc;
    assign bus.wr_data    = w_wr_data;
    assign bus.bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer; a second instance with a 4-bit counter exercises the wrap.
module tb_fifo_wr_packer;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    fifo_wr_packer_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) b ();
    fifo_wr_packer_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  s ();

    fifo_wr_packer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    fifo_wr_packer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        b.res_valid = 1'b0; b.res_wide = 1'b0; b.res_data = '0; b.wfull = 1'b0;
        s.res_valid = 1'b0; s.res_wide = 1'b0; s.res_data = '0; s.wfull = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(b.res_ready), 32'h1);
        chk("rst_busy",  32'(b.busy),      32'h0);
        chk("rst_winc",  32'(b.winc),      32'h0);
        chk("rst_wdata", 32'(b.wr_data),   32'h0);
        chk("rst_cnt",   32'(b.bytes_sent), 32'h0);

        // single byte A5
        b.res_valid = 1'b1; b.res_wide = 1'b0; b.res_data = 16'h00A5;
        #1;
        chk("t1_ready_idle", 32'(b.res_ready), 32'h1);
        tick();
        b.res_valid = 1'b0;
        #1;
        chk("t1_ready_lo", 32'(b.res_ready), 32'h0);
        chk("t1_busy_lo",  32'(b.busy),      32'h1);
        chk("t1_winc_lo",  32'(b.winc),      32'h1);
        chk("t1_data_lo",  32'(b.wr_data),   32'hA5);
        chk("t1_cnt_lo",   32'(b.bytes_sent), 32'h0);
        tick();
        chk("t1_ready_end", 32'(b.res_ready), 32'h1);
        chk("t1_winc_end",  32'(b.winc),      32'h0);
        chk("t1_busy_end",  32'(b.busy),      32'h0);
        chk("t1_cnt_end",   32'(b.bytes_sent), 32'h1);

        // wide BEEF, back to back
        b.res_valid = 1'b1; b.res_wide = 1'b1; b.res_data = 16'hBEEF;
        tick();
        b.res_valid = 1'b0;
        #1;
        chk("t2_winc_lo", 32'(b.winc),    32'h1);
        chk("t2_data_lo", 32'(b.wr_data), 32'hEF);
        chk("t2_busy_lo", 32'(b.busy),    32'h1);
        tick();
        chk("t2_winc_hi", 32'(b.winc),    32'h1);
        chk("t2_data_hi", 32'(b.wr_data), 32'hBE);
        chk("t2_busy_hi", 32'(b.busy),    32'h1);
        chk("t2_cnt_hi",  32'(b.bytes_sent), 32'h2);
        tick();
        chk("t2_busy_end", 32'(b.busy),       32'h0);
        chk("t2_winc_end", 32'(b.winc),       32'h0);
        chk("t2_cnt_end",  32'(b.bytes_sent), 32'h3);

        // wide 1234 with wfull held for 5 cycles in SEND_LO
        b.wfull = 1'b1;
        b.res_valid = 1'b1; b.res_wide = 1'b1; b.res_data = 16'h1234;
        tick();
        b.res_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_winc", 32'(b.winc),    32'h0);
            chk("t3_stall_data", 32'(b.wr_data), 32'h34);
            chk("t3_stall_busy", 32'(b.busy),    32'h1);
            tick();
        end
        chk("t3_stall_cnt", 32'(b.bytes_sent), 32'h3);
        b.wfull = 1'b0;
        #1;
        chk("t3_lo_winc", 32'(b.winc),    32'h1);
        chk("t3_lo_data", 32'(b.wr_data), 32'h34);
        tick();

        // wfull rises in the SEND_HI cycle
        b.wfull = 1'b1;
        #1;
        chk("t4_hi_stall_winc", 32'(b.winc),    32'h0);
        chk("t4_hi_stall_data", 32'(b.wr_data), 32'h12);
        tick();
        tick();
        chk("t4_hi_hold_data", 32'(b.wr_data),    32'h12);
        chk("t4_hi_hold_winc", 32'(b.winc),       32'h0);
        chk("t4_hi_hold_cnt",  32'(b.bytes_sent), 32'h4);
        b.wfull = 1'b0;
        #1;
        chk("t4_hi_winc", 32'(b.winc),    32'h1);
        chk("t4_hi_data", 32'(b.wr_data), 32'h12);
        tick();
        chk("t4_end_winc",  32'(b.winc),       32'h0);
        chk("t4_end_ready", 32'(b.res_ready),  32'h1);
        chk("t4_end_cnt",   32'(b.bytes_sent), 32'h5);

        // reset while in SEND_HI
        b.res_valid = 1'b1; b.res_wide = 1'b1; b.res_data = 16'hCAFE;
        tick();
        b.res_valid = 1'b0;
        tick();
        chk("t5_pre_data", 32'(b.wr_data),    32'hCA);
        chk("t5_pre_cnt",  32'(b.bytes_sent), 32'h6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(b.res_ready),  32'h1);
        chk("t5_rst_winc",  32'(b.winc),       32'h0);
        chk("t5_rst_busy",  32'(b.busy),       32'h0);
        chk("t5_rst_cnt",   32'(b.bytes_sent), 32'h0);
        chk("t5_rst_data",  32'(b.wr_data),    32'h0);

        // 4-bit counter wraps after 16 single-byte writes
        for (int i = 0; i < 16; i++) begin
            s.res_valid = 1'b1; s.res_wide = 1'b0; s.res_data = 16'(i + 8'h40);
            tick();
            s.res_valid = 1'b0;
            #1;
            chk("t6_data", 32'(s.wr_data), 32'(i + 8'h40));
            tick();
            if (i == 14) chk("t6_cnt_15", 32'(s.bytes_sent), 32'hF);
        end
        chk("t6_cnt_wrap", 32'(s.bytes_sent), 32'h0);
        chk("t6_main_idle_cnt", 32'(b.bytes_sent), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
